// File: rtl/nn_regbank_pkg.sv
// Shared constants for the neuron-core register bank: register indices, status bits, run FSM encoding.
package nn_regbank_pkg;

  localparam int IDX_W = 7;

  // Register indices past the coefficient block; add N_COEFF to get the absolute index.
  localparam int IDX_OFFSET = 0;
  localparam int IDX_INPUT  = 1;
  localparam int IDX_START  = 2;
  localparam int IDX_STATUS = 3;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } run_state_e;

endpackage

// File: rtl/nn_reg_addr_decode.sv
// Combinational bus-address decode shared by the write and read paths of the register bank.
module nn_reg_addr_decode
  import nn_regbank_pkg::*;
#(
  parameter int          N_COEFF = 20,
  parameter int          ADDR_W  = 9,
  parameter int unsigned BASE    = 32'h100
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic              aligned_o,
  output logic [IDX_W-1:0]  index_o
);

  localparam int unsigned LAST = BASE + 4 * (N_COEFF + 3);

  logic [31:0]       addr_ext;
  logic [ADDR_W-1:0] offs;

  assign addr_ext  = 32'(addr_i);
  assign offs      = addr_i - ADDR_W'(BASE);
  assign aligned_o = (addr_i[1:0] == 2'b00);
  // Range check only; callers combine it with aligned_o.
  assign hit_o     = (addr_ext >= BASE) && (addr_ext <= LAST);
  assign index_o   = IDX_W'(offs >> 2);

endmodule

// File: rtl/nn_coeff_regbank.sv
// Host-visible register bank and run FSM for the neuron core.
// Readback of coeff/offset/input is built only when NN_REG_READBACK_EN is defined; status is always readable.
module nn_coeff_regbank
  import nn_regbank_pkg::*;
#(
  parameter int          N_COEFF = 20,
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 9,
  parameter int unsigned BASE    = 32'h100
) (
  input  logic                      Clock_i,
  input  logic                      Reset_i,
  input  logic [ADDR_W-1:0]         Address_i,
  input  logic                      Write_i,
  input  logic                      Read_i,
  input  logic [DATA_W-1:0]         WriteData_i,
  output logic [DATA_W-1:0]         ReadData_o,
  output logic                      ReadValid_o,
  output logic [N_COEFF*DATA_W-1:0] CoeffFlat_o,
  output logic [DATA_W-1:0]         Offset_o,
  output logic [DATA_W-1:0]         Entrada_o,
  output logic                      StartPulse_o,
  input  logic                      CoreDone_i,
  output logic                      Busy_o,
  output logic                      WriteError_o
);

  localparam logic [IDX_W-1:0] I_OFF    = IDX_W'(N_COEFF + IDX_OFFSET);
  localparam logic [IDX_W-1:0] I_IN     = IDX_W'(N_COEFF + IDX_INPUT);
  localparam logic [IDX_W-1:0] I_START  = IDX_W'(N_COEFF + IDX_START);
  localparam logic [IDX_W-1:0] I_STATUS = IDX_W'(N_COEFF + IDX_STATUS);

  logic [DATA_W-1:0] coeff_q [N_COEFF];
  logic [DATA_W-1:0] coeff_d [N_COEFF];
  logic [DATA_W-1:0] offset_q, offset_d, input_q, input_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_val, status_val;
  logic              rvalid_q, done_q, done_d, err_q, err_d;
  run_state_e        state_q, state_d;

  logic              dec_hit, dec_aligned, mapped, busy;
  logic              wr_reg, wr_start, wr_status, err_set, done_set;
  logic [IDX_W-1:0]  dec_index;

  nn_reg_addr_decode #(
    .N_COEFF (N_COEFF),
    .ADDR_W  (ADDR_W),
    .BASE    (BASE)
  ) u_decode (
    .addr_i    (Address_i),
    .hit_o     (dec_hit),
    .aligned_o (dec_aligned),
    .index_o   (dec_index)
  );

  assign mapped    = dec_hit && dec_aligned;
  assign busy      = (state_q != IDLE);
  assign wr_reg    = Write_i && mapped && (dec_index < I_START);
  assign wr_start  = Write_i && mapped && (dec_index == I_START);
  assign wr_status = Write_i && mapped && (dec_index == I_STATUS);
  assign done_set  = (state_q == RUN) && CoreDone_i;
  assign err_set   = (Write_i && !mapped) || (wr_reg && busy) || (wr_start && busy);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    coeff_d  = coeff_q;
    offset_d = offset_q;
    input_d  = input_q;
    state_d  = state_q;

    if (wr_reg && !busy) begin
      if (dec_index == I_OFF) begin
        offset_d = WriteData_i;
      end else if (dec_index == I_IN) begin
        input_d = WriteData_i;
      end else begin
        for (int i = 0; i < N_COEFF; i++) begin
          if (dec_index == IDX_W'(i)) coeff_d[i] = WriteData_i;
        end
      end
    end

    unique case (state_q)
      IDLE:    if (wr_start) state_d = START;
      START:   state_d = RUN;
      RUN:     if (CoreDone_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A set event in the same cycle as a W1C clear keeps the flag set.
    done_d = done_set | (done_q & ~(wr_status & WriteData_i[ST_DONE]));
    err_d  = err_set  | (err_q  & ~(wr_status & WriteData_i[ST_ERR]));
  end

  always_comb begin
    status_val          = '0;
    status_val[ST_BUSY] = busy;
    status_val[ST_DONE] = done_q;
    status_val[ST_ERR]  = err_q;

    rd_val = '0;
    if (mapped) begin
`ifdef NN_REG_READBACK_EN
      if (dec_index == I_OFF) rd_val = offset_q;
      if (dec_index == I_IN)  rd_val = input_q;
      for (int i = 0; i < N_COEFF; i++) begin
        if (dec_index == IDX_W'(i)) rd_val = coeff_q[i];
      end
`endif
      if (dec_index == I_STATUS) rd_val = status_val;
    end
    rdata_d = Read_i ? rd_val : rdata_q;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      // NOTE: the coefficient array is reset too, because its contents drive the datapath directly.
      for (int i = 0; i < N_COEFF; i++) coeff_q[i] <= '0;
      offset_q <= '0;
      input_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= IDLE;
    end else begin
      coeff_q  <= coeff_d;
      offset_q <= offset_d;
      input_q  <= input_d;
      rdata_q  <= rdata_d;
      rvalid_q <= Read_i;
      done_q   <= done_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  for (genvar g = 0; g < N_COEFF; g++) begin : g_flat
    assign CoeffFlat_o[g*DATA_W +: DATA_W] = coeff_q[g];
  end

  assign Offset_o     = offset_q;
  assign Entrada_o    = input_q;
  assign ReadData_o   = rdata_q;
  assign ReadValid_o  = rvalid_q;
  assign StartPulse_o = (state_q == START);
  assign Busy_o       = busy;
  assign WriteError_o = err_q;

endmodule

// File: tb/tb_nn_coeff_regbank.sv
// Directed self-checking bench for nn_coeff_regbank (N_COEFF=20, BASE=0x100).
module tb_nn_coeff_regbank;

`ifdef NN_REG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [8:0]   addr = '0;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  logic [15:0]  wdata = '0;
  logic [15:0]  rdata;
  logic         rvalid;
  logic [319:0] coeff_flat;
  logic [15:0]  offset, entrada;
  logic         start_pulse, busy, werr;
  logic         core_done = 1'b0;

  int checks = 0;
  int errors = 0;

  nn_coeff_regbank dut (
    .Clock_i      (clk),
    .Reset_i      (rst),
    .Address_i    (addr),
    .Write_i      (wr),
    .Read_i       (rd),
    .WriteData_i  (wdata),
    .ReadData_o   (rdata),
    .ReadValid_o  (rvalid),
    .CoeffFlat_o  (coeff_flat),
    .Offset_o     (offset),
    .Entrada_o    (entrada),
    .StartPulse_o (start_pulse),
    .CoreDone_i   (core_done),
    .Busy_o       (busy),
    .WriteError_o (werr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; the write lands on the following posedge.
  task automatic bus_wr(input logic [8:0] a, input logic [15:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [8:0] a, input logic [15:0] exp);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check({tag, "_valid"}, 32'(rvalid), 32'd1);
    check({tag, "_data"}, 32'(rdata), 32'(exp));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(werr), 0);
    check("rst_start", 32'(start_pulse), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_coeff_or", 32'(|coeff_flat), 0);
    check("rst_offset", 32'(offset), 0);
    check("rst_input", 32'(entrada), 0);

    for (int i = 0; i < 24; i++) bus_rd("rst_read", 9'(9'h100 + 4 * i), 16'h0);

    bus_wr(9'h100, 16'h1234);
    bus_wr(9'h14C, 16'hBEEF);
    check("coeff0_flat", 32'(coeff_flat[15:0]), 32'h1234);
    check("coeff19_flat", 32'(coeff_flat[319:304]), 32'hBEEF);
    bus_rd("coeff0_rd", 9'h100, RB ? 16'h1234 : 16'h0);
    bus_rd("coeff19_rd", 9'h14C, RB ? 16'hBEEF : 16'h0);
    bus_wr(9'h150, 16'h0A0A);
    bus_wr(9'h154, 16'h0B0B);
    check("offset_out", 32'(offset), 32'h0A0A);
    check("input_out", 32'(entrada), 32'h0B0B);
    bus_rd("offset_rd", 9'h150, RB ? 16'h0A0A : 16'h0);
    bus_rd("input_rd", 9'h154, RB ? 16'h0B0B : 16'h0);
    check("err_clean", 32'(werr), 0);

    bus_wr(9'h158, 16'hFFFF);
    check("start_pulse_hi", 32'(start_pulse), 1);
    check("start_busy", 32'(busy), 1);
    @(negedge clk);
    check("start_pulse_lo", 32'(start_pulse), 0);
    check("run_busy", 32'(busy), 1);

    bus_wr(9'h104, 16'h0055);
    check("busy_wr_coeff1", 32'(coeff_flat[31:16]), 0);
    check("busy_wr_err", 32'(werr), 1);
    bus_rd("status_busy_err", 9'h15C, 16'h0005);
    bus_wr(9'h15C, 16'h0004);
    bus_rd("status_err_clr", 9'h15C, 16'h0001);
    bus_wr(9'h158, 16'h0000);
    check("restart_no_pulse", 32'(start_pulse), 0);
    bus_rd("status_restart", 9'h15C, 16'h0005);
    bus_wr(9'h15C, 16'h0004);

    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("done_busy_lo", 32'(busy), 0);
    bus_rd("status_done", 9'h15C, 16'h0002);
    bus_wr(9'h15C, 16'h0002);
    bus_rd("status_w1c", 9'h15C, 16'h0000);

    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    bus_rd("idle_done_ignored", 9'h15C, 16'h0000);

    bus_wr(9'h158, 16'h0000);
    @(negedge clk);
    addr = 9'h15C; wdata = 16'h0002; wr = 1'b1; core_done = 1'b1;
    @(negedge clk);
    wr = 1'b0; core_done = 1'b0;
    bus_rd("done_beats_w1c", 9'h15C, 16'h0002);
    bus_wr(9'h15C, 16'h0002);

    bus_wr(9'h102, 16'hFFFF);
    check("misalign_coeff0", 32'(coeff_flat[15:0]), 32'h1234);
    check("misalign_err", 32'(werr), 1);
    bus_wr(9'h15C, 16'h0004);
    check("err_cleared", 32'(werr), 0);
    bus_wr(9'h160, 16'hFFFF);
    check("unmapped_err", 32'(werr), 1);
    check("unmapped_coeff19", 32'(coeff_flat[319:304]), 32'hBEEF);
    check("unmapped_offset", 32'(offset), 32'h0A0A);
    check("unmapped_input", 32'(entrada), 32'h0B0B);
    bus_rd("unmapped_rd", 9'h160, 16'h0);
    bus_rd("misalign_rd", 9'h102, 16'h0);
    bus_wr(9'h15C, 16'h0004);

    addr = 9'h150; wdata = 16'h7777; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    check("rw_valid", 32'(rvalid), 1);
    check("rw_prewrite", 32'(rdata), RB ? 32'h0A0A : 32'h0);
    check("rw_offset_new", 32'(offset), 32'h7777);
    bus_rd("status_for_hold", 9'h15C, 16'h0000);
    bus_wr(9'h100, 16'h0001);
    check("rvalid_drop", 32'(rvalid), 0);
    bus_rd("start_addr_rd", 9'h158, 16'h0);

    bus_wr(9'h154, 16'h4242);
    bus_rd("input_hold_src", 9'h154, RB ? 16'h4242 : 16'h0);
    @(negedge clk);
    check("rdata_hold", 32'(rdata), RB ? 32'h4242 : 32'h0);

    bus_wr(9'h158, 16'h0000);
    @(negedge clk);
    check("pre_reset_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_run_busy", 32'(busy), 0);
    check("reset_run_pulse", 32'(start_pulse), 0);
    check("reset_run_coeff", 32'(|coeff_flat), 0);
    bus_rd("reset_run_status", 9'h15C, 16'h0000);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    bus_rd("late_done_status", 9'h15C, 16'h0000);
    check("late_done_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
